mem_byte_seq: RTL and testbench

Sequencer between the CPU memory request port and the 8-bit RAM. Splits each 16-bit word access into two byte accesses to the byte-wide memory. On reads, it captures each returned byte in an internal MDR and drives the MDR byte together with `byte_low_we` / `byte_high_we` into the downstream MDR byte shift register, which assembles the word. On writes, it issues the two byte stores directly.

---
 rtl/mem_byte_seq.sv | 142 ++++++++++++++
 tb/tb_mem_byte_seq.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_seq.sv
// Byte sequencer between the CPU word request port and a byte-wide RAM.
// Splits word accesses into two little-endian byte accesses and feeds read bytes to the MDR shift register.
module mem_byte_seq #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_wdata,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        byte_out,
  output logic              byte_low_we,
  output logic              byte_high_we
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_LO, S_WAIT_LO, S_PUT_LO, S_RD_HI, S_WAIT_HI, S_PUT_HI, S_WR_LO, S_WR_HI
  } state_t;

  localparam logic [2:0] WAIT_LOAD = 3'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic              r_byte;
  logic [15:0]       r_wdata;
  logic [2:0]        r_wait_cnt;
  logic [7:0]        r_mdr;
  logic              w_accept;
  logic              w_in_wait;
  logic              w_wait_done;
  logic [ADDR_W-1:0] w_addr_hi;

  assign w_accept    = req_valid && (r_state == S_IDLE);
  assign w_in_wait   = (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_wait_done = (r_wait_cnt == 3'd0);
  // High byte address wraps modulo 2^ADDR_W.
  assign w_addr_hi   = r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr;
      r_we    <= req_we;
      r_byte  <= req_byte;
      r_wdata <= req_wdata;
    end
  end

  // Wait counter is loaded in RD_x so WAIT_x lasts exactly RD_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 3'd0;
      r_mdr      <= 8'd0;
    end else begin
      if ((r_state == S_RD_LO) || (r_state == S_RD_HI)) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if (w_in_wait && !w_wait_done) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
      if (w_in_wait && w_wait_done) begin
        r_mdr <= mem_rdata;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    done         = 1'b0;
    mem_addr     = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_wdata    = 8'd0;
    byte_low_we  = 1'b0;
    byte_high_we = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = req_we ? S_WR_LO : S_RD_LO;
      end
      S_RD_LO: begin
        mem_addr = r_addr;
        mem_re   = 1'b1;
        w_next   = S_WAIT_LO;
      end
      S_WAIT_LO: if (w_wait_done) w_next = S_PUT_LO;
      S_PUT_LO: begin
        byte_low_we = 1'b1;
        done        = r_byte;
        w_next      = r_byte ? S_IDLE : S_RD_HI;
      end
      S_RD_HI: begin
        mem_addr = w_addr_hi;
        mem_re   = 1'b1;
        w_next   = S_WAIT_HI;
      end
      S_WAIT_HI: if (w_wait_done) w_next = S_PUT_HI;
      S_PUT_HI: begin
        byte_high_we = 1'b1;
        done         = 1'b1;
        w_next       = S_IDLE;
      end
      S_WR_LO: begin
        mem_addr  = r_addr;
        mem_wdata = r_wdata[7:0];
        mem_we    = 1'b1;
        done      = r_byte;
        w_next    = r_byte ? S_IDLE : S_WR_HI;
      end
      S_WR_HI: begin
        mem_addr  = w_addr_hi;
        mem_wdata = r_wdata[15:8];
        mem_we    = 1'b1;
        done      = 1'b1;
        w_next    = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign byte_out = r_mdr;

endmodule

// File: tb/tb_mem_byte_seq.sv
// Directed bench for mem_byte_seq: one instance with RD_LAT=1, one with RD_LAT=3,
// sharing a byte RAM model and each feeding its own downstream word register.
module tb_mem_byte_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld [2];
  logic        req_we, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        rdy [2], dn [2], m_re [2], m_we [2], blo [2], bhi [2];
  logic [15:0] m_addr [2];
  logic [7:0]  m_wdata [2], bout [2];
  logic [7:0]  rdata_l1, rdata_l3;

  logic [7:0]  ram [0:65535];
  logic [7:0]  pipe1;
  logic [7:0]  pipe3 [3];
  logic [15:0] word [2];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  int n_checks, n_pass;

  logic        t_rdy [32], t_dn [32], t_re [32], t_we [32], t_blo [32], t_bhi [32];
  logic [15:0] t_addr [32];
  logic [7:0]  t_wdata [32], t_bout [32];

  mem_byte_seq #(.ADDR_W(16), .RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(req_we),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .done(dn[0]),
    .mem_addr(m_addr[0]), .mem_re(m_re[0]), .mem_we(m_we[0]), .mem_wdata(m_wdata[0]),
    .mem_rdata(rdata_l1), .byte_out(bout[0]), .byte_low_we(blo[0]), .byte_high_we(bhi[0])
  );

  mem_byte_seq #(.ADDR_W(16), .RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(req_we),
    .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata), .done(dn[1]),
    .mem_addr(m_addr[1]), .mem_re(m_re[1]), .mem_we(m_we[1]), .mem_wdata(m_wdata[1]),
    .mem_rdata(rdata_l3), .byte_out(bout[1]), .byte_low_we(blo[1]), .byte_high_we(bhi[1])
  );

  // RAM model: read data appears RD_LAT cycles after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    for (int i = 0; i < 2; i++) begin
      if (m_we[i]) ram[m_addr[i]] <= m_wdata[i];
      if (blo[i]) word[i][7:0] <= bout[i];
      if (bhi[i]) word[i][15:8] <= bout[i];
    end
    pipe1    <= m_re[0] ? ram[m_addr[0]] : 8'hA5;
    pipe3[0] <= m_re[1] ? ram[m_addr[1]] : 8'hA5;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign rdata_l1 = pipe1;
  assign rdata_l3 = pipe3[2];

  task automatic preload(input logic [15:0] a, input logic [7:0] v);
    pl_addr = a; pl_data = v; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic sample(input int d, input int k);
    t_rdy[k] = rdy[d]; t_dn[k] = dn[d]; t_re[k] = m_re[d]; t_we[k] = m_we[d];
    t_blo[k] = blo[d]; t_bhi[k] = bhi[d]; t_addr[k] = m_addr[d];
    t_wdata[k] = m_wdata[d]; t_bout[k] = bout[d];
  endtask

  // Present one request to instance d in cycle 0, then trace cycles 1..n.
  task automatic issue(input int d, input logic we, input logic by, input logic [15:0] a,
                       input logic [15:0] wd, input int n, input int rst_at);
    req_we = we; req_byte = by; req_addr = a; req_wdata = wd; vld[d] = 1'b1;
    @(negedge clk); sample(d, 0);
    @(posedge clk); #1;
    vld[d] = 1'b0; req_addr = 16'h5A5A; req_wdata = 16'h1111; req_we = ~we; req_byte = ~by;
    for (int k = 1; k <= n; k++) begin
      rst = (k == rst_at);
      @(negedge clk); sample(d, k);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_checks++;
      if (rdy[d] !== 1'b1) $display("FAIL rst_ready dut%0d got=%b exp=1", d, rdy[d]); else n_pass++;
      n_checks++;
      if ({dn[d], m_re[d], m_we[d], blo[d], bhi[d]} !== 5'b0)
        $display("FAIL rst_strobes dut%0d got=%b exp=00000", d, {dn[d], m_re[d], m_we[d], blo[d], bhi[d]});
      else n_pass++;
      n_checks++;
      if (m_addr[d] !== 16'h0) $display("FAIL rst_addr dut%0d got=%h exp=0000", d, m_addr[d]); else n_pass++;
      n_checks++;
      if (m_wdata[d] !== 8'h0) $display("FAIL rst_wdata dut%0d got=%h exp=00", d, m_wdata[d]); else n_pass++;
      n_checks++;
      if (bout[d] !== 8'h0) $display("FAIL rst_byte_out dut%0d got=%h exp=00", d, bout[d]); else n_pass++;
    end
    @(posedge clk); #1;
    // Abort a RD_LAT=3 word read in WAIT_HI (cycles 7..9); reset edge ends cycle 8.
    preload(16'h0400, 8'h11);
    preload(16'h0401, 8'h22);
    issue(1, 1'b0, 1'b0, 16'h0400, 16'h0, 12, 8);
    n_checks++;
    if (t_blo[5] !== 1'b1) $display("FAIL abort_put_lo got=%b exp=1", t_blo[5]); else n_pass++;
    for (int k = 9; k <= 12; k++) begin
      n_checks++;
      if ({t_bhi[k], t_dn[k], t_re[k], t_rdy[k]} !== 4'b0001)
        $display("FAIL abort_idle cyc%0d got=%b exp=0001", k, {t_bhi[k], t_dn[k], t_re[k], t_rdy[k]});
      else n_pass++;
    end
    n_checks++;
    if (t_bout[9] !== 8'h00) $display("FAIL abort_mdr_clear got=%h exp=00", t_bout[9]); else n_pass++;
  endtask

  task automatic test_word_read();
    preload(16'h0100, 8'h34);
    preload(16'h0101, 8'h12);
    issue(0, 1'b0, 1'b0, 16'h0100, 16'h0, 7, 0);
    for (int k = 1; k <= 7; k++) begin
      logic [4:0] exp_v;
      exp_v = {(k == 1) || (k == 4), 1'b0, k == 3, k == 6, k == 6};
      n_checks++;
      if ({t_re[k], t_we[k], t_blo[k], t_bhi[k], t_dn[k]} !== exp_v)
        $display("FAIL wrd_strobes cyc%0d got=%b exp=%b", k, {t_re[k], t_we[k], t_blo[k], t_bhi[k], t_dn[k]}, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (t_addr[1] !== 16'h0100) $display("FAIL wrd_addr_lo got=%h exp=0100", t_addr[1]); else n_pass++;
    n_checks++;
    if (t_addr[4] !== 16'h0101) $display("FAIL wrd_addr_hi got=%h exp=0101", t_addr[4]); else n_pass++;
    n_checks++;
    if (t_bout[3] !== 8'h34) $display("FAIL wrd_byte_lo got=%h exp=34", t_bout[3]); else n_pass++;
    n_checks++;
    if (t_bout[6] !== 8'h12) $display("FAIL wrd_byte_hi got=%h exp=12", t_bout[6]); else n_pass++;
    n_checks++;
    if (word[0] !== 16'h1234) $display("FAIL wrd_word got=%h exp=1234", word[0]); else n_pass++;
    n_checks++;
    if ({t_rdy[2], t_rdy[7]} !== 2'b01) $display("FAIL wrd_ready got=%b exp=01", {t_rdy[2], t_rdy[7]}); else n_pass++;
  endtask

  task automatic test_wrap_read();
    preload(16'hFFFF, 8'hCD);
    preload(16'h0000, 8'hAB);
    issue(1, 1'b0, 1'b0, 16'hFFFF, 16'h0, 11, 0);
    n_checks++;
    if (t_addr[1] !== 16'hFFFF || t_re[1] !== 1'b1) $display("FAIL wrap_addr_lo got=%h/%b exp=ffff/1", t_addr[1], t_re[1]); else n_pass++;
    n_checks++;
    if (t_addr[6] !== 16'h0000 || t_re[6] !== 1'b1) $display("FAIL wrap_addr_hi got=%h/%b exp=0000/1", t_addr[6], t_re[6]); else n_pass++;
    for (int k = 1; k <= 11; k++) begin
      n_checks++;
      if (t_dn[k] !== (k == 10)) $display("FAIL wrap_done cyc%0d got=%b exp=%b", k, t_dn[k], k == 10); else n_pass++;
    end
    n_checks++;
    if (t_blo[5] !== 1'b1 || t_bout[5] !== 8'hCD) $display("FAIL wrap_byte_lo got=%b/%h exp=1/cd", t_blo[5], t_bout[5]); else n_pass++;
    n_checks++;
    if (word[1] !== 16'hABCD) $display("FAIL wrap_word got=%h exp=abcd", word[1]); else n_pass++;
  endtask

  task automatic test_word_write();
    issue(0, 1'b1, 1'b0, 16'h0203, 16'hBEEF, 3, 0);
    n_checks++;
    if ({t_we[1], t_dn[1], t_addr[1], t_wdata[1]} !== {2'b10, 16'h0203, 8'hEF})
      $display("FAIL ww_cyc1 got=%b%b %h %h exp=10 0203 ef", t_we[1], t_dn[1], t_addr[1], t_wdata[1]);
    else n_pass++;
    n_checks++;
    if ({t_we[2], t_dn[2], t_addr[2], t_wdata[2]} !== {2'b11, 16'h0204, 8'hBE})
      $display("FAIL ww_cyc2 got=%b%b %h %h exp=11 0204 be", t_we[2], t_dn[2], t_addr[2], t_wdata[2]);
    else n_pass++;
    n_checks++;
    if ({t_rdy[3], t_we[3]} !== 2'b10) $display("FAIL ww_ready3 got=%b exp=10", {t_rdy[3], t_we[3]}); else n_pass++;
    n_checks++;
    if ({t_re[1], t_re[2], t_blo[1], t_bhi[1], t_blo[2], t_bhi[2]} !== 6'b0)
      $display("FAIL ww_no_read_strobes got=%b exp=000000", {t_re[1], t_re[2], t_blo[1], t_bhi[1], t_blo[2], t_bhi[2]});
    else n_pass++;
    n_checks++;
    if ({ram[16'h0204], ram[16'h0203]} !== 16'hBEEF) $display("FAIL ww_ram got=%h exp=beef", {ram[16'h0204], ram[16'h0203]}); else n_pass++;
  endtask

  task automatic test_byte_access();
    preload(16'h0010, 8'h7A);
    issue(0, 1'b0, 1'b1, 16'h0010, 16'h0, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      logic [3:0] exp_v;
      exp_v = {k == 1, k == 3, 1'b0, k == 3};
      n_checks++;
      if ({t_re[k], t_blo[k], t_bhi[k], t_dn[k]} !== exp_v)
        $display("FAIL br_strobes cyc%0d got=%b exp=%b", k, {t_re[k], t_blo[k], t_bhi[k], t_dn[k]}, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (t_bout[3] !== 8'h7A) $display("FAIL br_byte got=%h exp=7a", t_bout[3]); else n_pass++;
    n_checks++;
    if (word[0] !== 16'h127A) $display("FAIL br_word got=%h exp=127a", word[0]); else n_pass++;
    preload(16'h0301, 8'h99);
    issue(1, 1'b1, 1'b1, 16'h0300, 16'hAA55, 2, 0);
    n_checks++;
    if ({t_we[1], t_dn[1], t_addr[1], t_wdata[1]} !== {2'b11, 16'h0300, 8'h55})
      $display("FAIL bw_cyc1 got=%b%b %h %h exp=11 0300 55", t_we[1], t_dn[1], t_addr[1], t_wdata[1]);
    else n_pass++;
    n_checks++;
    if ({t_we[2], t_rdy[2]} !== 2'b01) $display("FAIL bw_cyc2 got=%b exp=01", {t_we[2], t_rdy[2]}); else n_pass++;
    n_checks++;
    if ({ram[16'h0301], ram[16'h0300]} !== 16'h9955) $display("FAIL bw_ram got=%h exp=9955", {ram[16'h0301], ram[16'h0300]}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int acc, wes, res, dns, clash;
    // Word writes with req_valid held: accepts every third cycle.
    req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0500; req_wdata = 16'h5678; vld[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); sample(0, k);
      @(posedge clk); #1;
    end
    vld[0] = 1'b0;
    acc = 0; wes = 0; dns = 0; clash = 0;
    for (int k = 0; k < 12; k++) begin
      acc += int'(t_rdy[k]); wes += int'(t_we[k]); dns += int'(t_dn[k]);
      clash += int'((t_re[k] && t_we[k]) || t_blo[k] || t_bhi[k]);
    end
    n_checks++;
    if ({acc, wes, dns, clash} !== {32'd4, 32'd8, 32'd4, 32'd0})
      $display("FAIL b2b_wr acc/we/done/clash got=%0d/%0d/%0d/%0d exp=4/8/4/0", acc, wes, dns, clash);
    else n_pass++;
    n_checks++;
    if ({ram[16'h0501], ram[16'h0500]} !== 16'h5678) $display("FAIL b2b_wr_ram got=%h exp=5678", {ram[16'h0501], ram[16'h0500]}); else n_pass++;
    // Byte reads at RD_LAT=3 with req_valid held: accepts every sixth cycle.
    req_we = 1'b0; req_byte = 1'b1; req_addr = 16'h0010; vld[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); sample(1, k);
      @(posedge clk); #1;
    end
    vld[1] = 1'b0;
    acc = 0; res = 0; dns = 0; clash = 0;
    for (int k = 0; k < 12; k++) begin
      acc += int'(t_rdy[k]); res += int'(t_re[k]); dns += int'(t_dn[k]);
      clash += int'((t_re[k] && t_we[k]) || (t_blo[k] && t_bhi[k]) || t_bhi[k]);
    end
    n_checks++;
    if ({acc, res, dns, clash} !== {32'd2, 32'd2, 32'd2, 32'd0})
      $display("FAIL b2b_rd acc/re/done/clash got=%0d/%0d/%0d/%0d exp=2/2/2/0", acc, res, dns, clash);
    else n_pass++;
    n_checks++;
    if ({t_dn[5], t_dn[11], t_rdy[6]} !== 3'b111) $display("FAIL b2b_rd_timing got=%b exp=111", {t_dn[5], t_dn[11], t_rdy[6]}); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; vld[0] = 1'b0; vld[1] = 1'b0; pl_en = 1'b0; pl_addr = 16'h0; pl_data = 8'h0;
    req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
    test_reset();
    test_word_read();
    test_wrap_read();
    test_word_write();
    test_byte_access();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
